// File: rtl/round_ctrl.sv
// round_ctrl: memory-game round FSM (request, show, collect keys, score).
// Define ROUND_TIMEOUT_EN to fail a round when the player stalls in INPUT.
module round_ctrl #(
  parameter int SYMBOLS       = 5,
  parameter int SHOW_TICKS    = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        tick_i,
  input  logic        new_seq_i,
  input  logic [19:0] seq_in_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  output logic        req_seq_o,
  output logic        disp_en_o,
  output logic [3:0]  disp_digit_o,
  output logic [2:0]  disp_idx_o,
  output logic        busy_o,
  output logic        round_done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic [7:0]  score_o
);
  localparam int SW = SHOW_TICKS > 0 ? $clog2(SHOW_TICKS + 1) : 1;
  localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_SEQ, SHOW, GAP, INPUT, RESULT} state_e;
  state_e          state_q;
  logic [19:0]     seq_q;
  logic [2:0]      idx_q, idx_d;
  logic [SW-1:0]   show_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic            kv_q;
  logic [3:0]      kc_q, sym_cur, sym_nxt, disp_digit_q;
  logic            req_seq_q, disp_en_q, round_done_q, pass_q, fail_q;
  logic [7:0]      score_q, score_inc;
  logic            gap_done, last, hit;
`ifdef ROUND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0]   to_cnt_q;
`endif
  assign idx_d     = idx_q + 3'd1;
  assign sym_cur   = 4'(seq_q >> {idx_q, 2'b00});
  assign sym_nxt   = 4'(seq_q >> {idx_d, 2'b00});
  assign gap_done  = (GAP_TICKS == 0) || (tick_i && gap_cnt_q == GW'(GAP_TICKS - 1));
  assign last      = idx_q == 3'(SYMBOLS - 1);
  assign hit       = kc_q == sym_cur;
  assign score_inc = score_q + {7'd0, score_q != 8'hFF};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      idx_q        <= '0;
      show_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      kv_q         <= 1'b0;
      kc_q         <= '0;
      req_seq_q    <= 1'b0;
      disp_en_q    <= 1'b0;
      disp_digit_q <= '0;
      round_done_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      score_q      <= '0;
`ifdef ROUND_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      req_seq_q    <= 1'b0;
      round_done_q <= 1'b0;
      // keys are registered first, so only presses made while in INPUT count
      kv_q         <= key_valid_i && state_q == INPUT;
      kc_q         <= key_code_i;
      case (state_q)
        IDLE: if (start_i) begin
          state_q   <= REQ;
          req_seq_q <= 1'b1;
          pass_q    <= 1'b0;
          fail_q    <= 1'b0;
        end
        REQ: state_q <= WAIT_SEQ;
        WAIT_SEQ: if (new_seq_i) begin
          state_q      <= SHOW;
          seq_q        <= seq_in_i;
          idx_q        <= '0;
          show_cnt_q   <= '0;
          disp_en_q    <= 1'b1;
          disp_digit_q <= seq_in_i[3:0];
        end
        SHOW: if (tick_i) begin
          if (show_cnt_q == SW'(SHOW_TICKS - 1)) begin
            state_q      <= GAP;
            show_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            disp_en_q    <= 1'b0;
            disp_digit_q <= '0;
          end else show_cnt_q <= show_cnt_q + 1'b1;
        end
        GAP: if (gap_done) begin
          gap_cnt_q <= '0;
          if (last) begin
            state_q  <= INPUT;
            idx_q    <= '0;
`ifdef ROUND_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else begin
            state_q      <= SHOW;
            idx_q        <= idx_d;
            show_cnt_q   <= '0;
            disp_en_q    <= 1'b1;
            disp_digit_q <= sym_nxt;
          end
        end else if (tick_i) gap_cnt_q <= gap_cnt_q + 1'b1;
        INPUT: if (kv_q) begin
`ifdef ROUND_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          if (!hit || last) begin
            state_q      <= RESULT;
            round_done_q <= 1'b1;
            pass_q       <= hit;
            fail_q       <= !hit;
            score_q      <= hit ? score_inc : 8'd0;
          end else idx_q <= idx_d;
        end
`ifdef ROUND_TIMEOUT_EN
        // a key in the same cycle as the expiring tick wins over the timeout
        else if (tick_i && !key_valid_i) begin
          if (to_cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
            state_q      <= RESULT;
            round_done_q <= 1'b1;
            fail_q       <= 1'b1;
            score_q      <= '0;
          end else to_cnt_q <= to_cnt_q + 1'b1;
        end
`endif
        RESULT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_seq_o    = req_seq_q;
  assign disp_en_o    = disp_en_q;
  assign disp_digit_o = disp_digit_q;
  assign disp_idx_o   = idx_q;
  assign busy_o       = state_q != IDLE;
  assign round_done_o = round_done_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign score_o      = score_q;
endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: table of whole-round vectors plus directed reset, saturation and ignore sequences.
module tb_round_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_i = 1'b0, tick_i = 1'b0, new_seq_i = 1'b0, key_valid_i = 1'b0;
  logic [19:0] seq_in_i = '0;
  logic [3:0]  key_code_i = '0;
  logic        req_seq_o, disp_en_o, busy_o, round_done_o, pass_o, fail_o;
  logic [3:0]  disp_digit_o;
  logic [2:0]  disp_idx_o;
  logic [7:0]  score_o;
  int passed = 0, total = 0;
  bit quiet = 1'b0;

  round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .tick_i(tick_i), .new_seq_i(new_seq_i),
    .seq_in_i(seq_in_i), .key_valid_i(key_valid_i), .key_code_i(key_code_i),
    .req_seq_o(req_seq_o), .disp_en_o(disp_en_o), .disp_digit_o(disp_digit_o),
    .disp_idx_o(disp_idx_o), .busy_o(busy_o), .round_done_o(round_done_o),
    .pass_o(pass_o), .fail_o(fail_o), .score_o(score_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] seq;
    logic [19:0] keys;
    int          nk;
    logic        exp_pass;
    int          exp_score;
    logic        noise;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    if (!quiet) begin
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, req_seq_o, 0);
    chk({nm, "_disp_en"}, disp_en_o, 0);
    chk({nm, "_digit"}, disp_digit_o, 0);
    chk({nm, "_idx"}, disp_idx_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, round_done_o, 0);
    chk({nm, "_pass"}, pass_o, 0);
    chk({nm, "_fail"}, fail_o, 0);
    chk({nm, "_score"}, score_o, 0);
  endtask

  // start a round and answer the request three cycles after req_seq
  task automatic start_round(input logic [19:0] seq);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("req_seq", req_seq_o, 1);
    chk("busy_req", busy_o, 1);
    chk("pass_clr", pass_o, 0);
    chk("fail_clr", fail_o, 0);
    @(negedge clk);
    chk("req_one_cycle", req_seq_o, 0);
    @(negedge clk);
    chk("wait_dark", disp_en_o, 0);
    new_seq_i = 1'b1;
    seq_in_i  = seq;
    @(negedge clk);
    new_seq_i = 1'b0;
    seq_in_i  = ~seq;
  endtask

  task automatic play(input logic [19:0] seq, input logic noise);
    int sh[5];
    int gp[5];
    int cur, o;
    bit done;
    logic t;
    for (int k = 0; k < 5; k++) begin sh[k] = 0; gp[k] = 0; end
    cur = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!disp_en_o && disp_idx_o == 0 && cur == 4) done = 1'b1;
      else begin
        o = int'(disp_idx_o);
        if (o != cur) begin
          chk("idx_step", o, cur + 1);
          cur = o > 4 ? 4 : o;
        end
        t = (c % 3) != 2;
        if (disp_en_o) begin
          chk("digit", disp_digit_o, seq[4*cur +: 4]);
          if (t) sh[cur]++;
        end else if (t) gp[cur]++;
        chk("req_quiet", req_seq_o, 0);
        tick_i      = t;
        start_i     = noise;
        key_valid_i = noise;
        key_code_i  = seq[4*cur +: 4];
        @(negedge clk);
      end
    end
    tick_i = 1'b0;
    start_i = 1'b0;
    key_valid_i = 1'b0;
    chk("reach_input", done, 1);
    for (int k = 0; k < 5; k++) begin
      chk("show_ticks", sh[k], 4);
      chk("gap_ticks", gp[k], 1);
    end
  endtask

  task automatic key(input logic [3:0] code, input bit last, input logic ep, input int es, input int j);
    key_valid_i = 1'b1;
    key_code_i  = code;
    @(negedge clk);
    key_valid_i = 1'b0;
    key_code_i  = ~code;
    @(negedge clk);
    if (last) begin
      chk("round_done", round_done_o, 1);
      chk("pass", pass_o, ep);
      chk("fail", fail_o, !ep);
      chk("score", score_o, es);
      @(negedge clk);
      chk("done_pulse", round_done_o, 0);
      chk("idle_after", busy_o, 0);
      chk("pass_hold", pass_o, ep);
      chk("fail_hold", fail_o, !ep);
    end else begin
      chk("idx_adv", disp_idx_o, j + 1);
      chk("no_done", round_done_o, 0);
      chk("busy_input", busy_o, 1);
    end
  endtask

  task automatic run(input vec_t v);
    start_round(v.seq);
    play(v.seq, v.noise);
    chk("input_dark", disp_en_o, 0);
    chk("input_idx0", disp_idx_o, 0);
    for (int j = 0; j < v.nk; j++) key(v.keys[4*j +: 4], j == v.nk - 1, v.exp_pass, v.exp_score, j);
    repeat (2) begin
      @(negedge clk);
      chk("post_dark", disp_en_o, 0);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{20'h4A3C1, 20'h4A3C1, 5, 1'b1, 1, 1'b0};
    vecs[1] = '{20'h4A3C1, 20'h00051, 2, 1'b0, 0, 1'b0};
    vecs[2] = '{20'h12345, 20'h12345, 5, 1'b1, 1, 1'b1};
    vecs[3] = '{20'hFFFFF, 20'hFFFFF, 5, 1'b1, 2, 1'b0};
    vecs[4] = '{20'h00000, 20'h10000, 5, 1'b0, 0, 1'b1};
    vecs[5] = '{20'hABCDE, 20'hABCDE, 5, 1'b1, 1, 1'b0};
    vecs[6] = '{20'h4A3C1, 20'h00002, 1, 1'b0, 0, 1'b0};
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    new_seq_i = 1'b1;
    seq_in_i = 20'h12345;
    key_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_newseq_busy", busy_o, 0);
      chk("idle_newseq_req", req_seq_o, 0);
      chk("idle_newseq_disp", disp_en_o, 0);
    end
    new_seq_i = 1'b0;
    key_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) run(vecs[i]);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 254; i++) run(vecs[0]);
    quiet = 1'b0;
    v = vecs[0];
    v.exp_score = 255;
    run(v);
    run(v);

    start_round(vecs[0].seq);
    play(vecs[0].seq, 1'b0);
`ifndef ROUND_TIMEOUT_EN
    tick_i = 1'b1;
    repeat (40) @(negedge clk);
    tick_i = 1'b0;
    chk("no_timeout_busy", busy_o, 1);
    chk("no_timeout_fail", fail_o, 0);
`endif
    key(4'h1, 1'b0, 1'b0, 0, 0);
    key(4'hC, 1'b0, 1'b0, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    new_seq_i = 1'b1;
    seq_in_i = 20'h4A3C1;
    @(negedge clk);
    new_seq_i = 1'b0;
    chk("late_gen_busy", busy_o, 0);
    chk("late_gen_disp", disp_en_o, 0);
    run(vecs[0]);

`ifdef ROUND_TIMEOUT_EN
    start_round(vecs[0].seq);
    play(vecs[0].seq, 1'b0);
    tick_i = 1'b1;
    repeat (19) @(negedge clk);
    chk("to_19_fail", fail_o, 0);
    @(negedge clk);
    tick_i = 1'b0;
    chk("to_20_fail", fail_o, 1);
    chk("to_20_done", round_done_o, 1);
    @(negedge clk);
    start_round(vecs[0].seq);
    play(vecs[0].seq, 1'b0);
    tick_i = 1'b1;
    repeat (19) @(negedge clk);
    key_valid_i = 1'b1;
    key_code_i = 4'h1;
    @(negedge clk);
    key_valid_i = 1'b0;
    tick_i = 1'b0;
    chk("to_key_wins_fail", fail_o, 0);
    chk("to_key_wins_done", round_done_o, 0);
    @(negedge clk);
    chk("to_key_idx", disp_idx_o, 1);
    tick_i = 1'b1;
    repeat (19) @(negedge clk);
    chk("to_restart_fail", fail_o, 0);
    @(negedge clk);
    tick_i = 1'b0;
    chk("to_restart_expire", fail_o, 1);
    @(negedge clk);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
